// File: rtl/inst_encoder.sv
// RV32I I/S/B/J instruction encoder with range/alignment checking, a 2-entry
// output FIFO and good/error request counters.
module inst_encoder #(
    parameter int CNT_W = 16,
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_fmt,
    input  logic             in_load,
    input  logic [4:0]       in_rd,
    input  logic [4:0]       in_rs1,
    input  logic [4:0]       in_rs2,
    input  logic [2:0]       in_funct3,
    input  logic [31:0]      in_imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_inst,
    output logic             out_err,
    output logic [CNT_W-1:0] inst_count,
    output logic [ERR_W-1:0] err_count
);

    localparam logic [1:0] FMT_I = 2'd0;
    localparam logic [1:0] FMT_S = 2'd1;
    localparam logic [1:0] FMT_B = 2'd2;
    localparam logic [1:0] FMT_J = 2'd3;

    localparam logic [6:0]  OP_LOAD   = 7'b0000011;
    localparam logic [6:0]  OP_IMM    = 7'b0010011;
    localparam logic [6:0]  OP_STORE  = 7'b0100011;
    localparam logic [6:0]  OP_BRANCH = 7'b1100011;
    localparam logic [6:0]  OP_JAL    = 7'b1101111;
    localparam logic [31:0] NOP_INST  = 32'h00000013;

    logic        w_fits12;
    logic        w_fits13;
    logic        w_fits21;
    logic        w_legal;
    logic [31:0] w_enc;
    logic [31:0] w_new_inst;
    logic        w_push;
    logic        w_pop;

    logic [1:0]       r_count;
    logic [31:0]      r_head_inst;
    logic             r_head_err;
    logic [31:0]      r_tail_inst;
    logic             r_tail_err;
    logic [CNT_W-1:0] r_inst_count;
    logic [ERR_W-1:0] r_err_count;

    // An immediate fits in N signed bits when every bit above N-2 matches the sign.
    assign w_fits12 = (&in_imm[31:11]) | ~(|in_imm[31:11]);
    assign w_fits13 = (&in_imm[31:12]) | ~(|in_imm[31:12]);
    assign w_fits21 = (&in_imm[31:20]) | ~(|in_imm[31:20]);

    always_comb begin
        w_enc   = NOP_INST;
        w_legal = 1'b0;
        case (in_fmt)
            FMT_I: begin
                w_legal = w_fits12;
                w_enc   = {in_imm[11:0], in_rs1, in_funct3, in_rd,
                           in_load ? OP_LOAD : OP_IMM};
            end
            FMT_S: begin
                w_legal = w_fits12;
                w_enc   = {in_imm[11:5], in_rs2, in_rs1, in_funct3,
                           in_imm[4:0], OP_STORE};
            end
            FMT_B: begin
                w_legal = w_fits13 & ~in_imm[0];
                w_enc   = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                           in_imm[4:1], in_imm[11], OP_BRANCH};
            end
            default: begin
                w_legal = w_fits21 & ~in_imm[0];
                w_enc   = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                           in_rd, OP_JAL};
            end
        endcase
    end

    assign w_new_inst = w_legal ? w_enc : NOP_INST;

    assign in_ready  = (r_count != 2'd2);
    assign out_valid = (r_count != 2'd0);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;
    assign out_inst  = r_head_inst;
    assign out_err   = r_head_err;

    // Head register drives the outputs directly, so it keeps the last popped
    // entry when the FIFO drains; the tail only holds the second entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count     <= 2'd0;
            r_head_inst <= 32'd0;
            r_head_err  <= 1'b0;
            r_tail_inst <= 32'd0;
            r_tail_err  <= 1'b0;
        end else begin
            case (r_count)
                2'd0: begin
                    if (w_push) begin
                        r_head_inst <= w_new_inst;
                        r_head_err  <= ~w_legal;
                        r_count     <= 2'd1;
                    end
                end
                2'd1: begin
                    if (w_push && w_pop) begin
                        r_head_inst <= w_new_inst;
                        r_head_err  <= ~w_legal;
                    end else if (w_push) begin
                        r_tail_inst <= w_new_inst;
                        r_tail_err  <= ~w_legal;
                        r_count     <= 2'd2;
                    end else if (w_pop) begin
                        r_count <= 2'd0;
                    end
                end
                default: begin
                    if (w_pop) begin
                        r_head_inst <= r_tail_inst;
                        r_head_err  <= r_tail_err;
                        r_count     <= 2'd1;
                    end
                end
            endcase
        end
    end

    // Counters track accepted requests, independent of when they are popped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inst_count <= '0;
            r_err_count  <= '0;
        end else if (w_push) begin
            if (w_legal) begin
                r_inst_count <= r_inst_count + CNT_W'(1);
            end else if (r_err_count != {ERR_W{1'b1}}) begin
                r_err_count <= r_err_count + ERR_W'(1);
            end
        end
    end

    assign inst_count = r_inst_count;
    assign err_count  = r_err_count;

endmodule

// File: tb/tb_inst_encoder.sv
// Self-checking bench for inst_encoder: directed encodings, error and
// backpressure cases, then randomized traffic against a queue-based model.
module tb_inst_encoder;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_fmt;
    logic        in_load;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [2:0]  in_funct3;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic        out_err;
    logic [15:0] inst_count;
    logic [7:0]  err_count;

    int assertCount = 0;
    int failCount   = 0;

    typedef struct {
        logic [31:0] inst;
        logic        err;
        logic [31:0] imm;
        logic [1:0]  fmt;
    } entry_t;

    entry_t modelQ[$];
    entry_t lastPopped;
    int     modelInst;
    int     modelErr;

    inst_encoder #(.CNT_W(16), .ERR_W(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_fmt(in_fmt), .in_load(in_load), .in_rd(in_rd),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct3(in_funct3),
        .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_inst(out_inst), .out_err(out_err),
        .inst_count(inst_count), .err_count(err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    // Legality is judged on the numeric value, encoding from the field layout.
    function automatic entry_t modelEncode(input logic [1:0] fmt, input logic load,
                                           input logic [4:0] rd, input logic [4:0] rs1,
                                           input logic [4:0] rs2, input logic [2:0] f3,
                                           input logic [31:0] imm);
        entry_t e;
        int v;
        bit legal;
        v = int'($signed(imm));
        case (fmt)
            2'd0, 2'd1: legal = (v >= -2048) && (v <= 2047);
            2'd2:       legal = (v >= -4096) && (v <= 4094) && (v % 2 == 0);
            default:    legal = (v >= -1048576) && (v <= 1048574) && (v % 2 == 0);
        endcase
        case (fmt)
            2'd0:    e.inst = {imm[11:0], rs1, f3, rd, load ? 7'b0000011 : 7'b0010011};
            2'd1:    e.inst = {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
            2'd2:    e.inst = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
            default: e.inst = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
        endcase
        if (!legal) e.inst = 32'h00000013;
        e.err = !legal;
        e.imm = imm;
        e.fmt = fmt;
        return e;
    endfunction

    function automatic logic [31:0] decodeImm(input logic [31:0] i, input logic [1:0] fmt);
        case (fmt)
            2'd0:    return {{20{i[31]}}, i[31:20]};
            2'd1:    return {{20{i[31]}}, i[31:25], i[11:7]};
            2'd2:    return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            default: return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
        endcase
    endfunction

    function automatic void modelReset();
        modelQ.delete();
        lastPopped.inst = 32'd0;
        lastPopped.err  = 1'b0;
        lastPopped.imm  = 32'd0;
        lastPopped.fmt  = 2'd0;
        modelInst = 0;
        modelErr  = 0;
    endfunction

    task automatic applyStimulus(input logic [1:0] fmt, input logic load, input logic [4:0] rd,
                                 input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic [2:0] f3, input logic [31:0] imm);
        in_fmt = fmt; in_load = load; in_rd = rd; in_rs1 = rs1;
        in_rs2 = rs2; in_funct3 = f3; in_imm = imm;
    endtask

    // Checks all outputs against the model, then advances one clock edge.
    task automatic stepCycle();
        entry_t e;
        entry_t head;
        bit push;
        bit pop;
        head = (modelQ.size() > 0) ? modelQ[0] : lastPopped;
        checkOutput("in_ready", {31'd0, in_ready}, {31'd0, modelQ.size() < 2});
        checkOutput("out_valid", {31'd0, out_valid}, {31'd0, modelQ.size() > 0});
        checkOutput("out_inst", out_inst, head.inst);
        checkOutput("out_err", {31'd0, out_err}, {31'd0, head.err});
        checkOutput("inst_count", {16'd0, inst_count}, modelInst & 32'hFFFF);
        checkOutput("err_count", {24'd0, err_count}, modelErr);
        push = in_valid && (modelQ.size() < 2);
        pop  = (modelQ.size() > 0) && out_ready;
        e = modelEncode(in_fmt, in_load, in_rd, in_rs1, in_rs2, in_funct3, in_imm);
        if (pop && !modelQ[0].err)
            checkOutput("roundtrip_imm", decodeImm(out_inst, modelQ[0].fmt), modelQ[0].imm);
        @(posedge clk);
        #1;
        if (pop) lastPopped = modelQ.pop_front();
        if (push) begin
            modelQ.push_back(e);
            if (e.err) modelErr = (modelErr < 255) ? modelErr + 1 : 255;
            else modelInst = modelInst + 1;
        end
    endtask

    task automatic sendReq(input logic [1:0] fmt, input logic load, input logic [4:0] rd,
                           input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [2:0] f3, input logic [31:0] imm);
        bit accepted;
        applyStimulus(fmt, load, rd, rs1, rs2, f3, imm);
        in_valid = 1'b1;
        for (int n = 0; n < 20; n++) begin
            accepted = (modelQ.size() < 2);
            stepCycle();
            if (accepted) return;
        end
        checkOutput("accept_timeout", 32'd0, 32'd1);
    endtask

    // One request into an empty FIFO, compared against a fixed expected word.
    task automatic directedReq(input string tag, input logic [1:0] fmt, input logic load,
                               input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [2:0] f3, input logic [31:0] imm,
                               input logic [31:0] expInst, input logic expErr);
        sendReq(fmt, load, rd, rs1, rs2, f3, imm);
        in_valid = 1'b0;
        checkOutput({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        checkOutput({tag, "_inst"}, out_inst, expInst);
        checkOutput({tag, "_err"}, {31'd0, out_err}, {31'd0, expErr});
        stepCycle();
    endtask

    function automatic logic [31:0] randLegalImm(input logic [1:0] fmt);
        case (fmt)
            2'd0, 2'd1: return 32'(int'($urandom_range(0, 4095)) - 2048);
            2'd2:       return 32'((int'($urandom_range(0, 4095)) - 2048) * 2);
            default:    return 32'((int'($urandom_range(0, 1048575)) - 524288) * 2);
        endcase
    endfunction

    task automatic randomReq(input bit wantLegal);
        logic [1:0]  fmt;
        logic [31:0] imm;
        entry_t e;
        fmt = 2'($urandom_range(0, 3));
        if (wantLegal) begin
            imm = randLegalImm(fmt);
        end else begin
            imm = $urandom;
            for (int k = 0; k < 50; k++) begin
                e = modelEncode(fmt, 1'b0, 5'd0, 5'd0, 5'd0, 3'd0, imm);
                if (e.err) break;
                imm = $urandom;
            end
        end
        applyStimulus(fmt, 1'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                      3'($urandom), imm);
    endtask

    initial begin
        logic [31:0] bounds [12];
        logic [1:0]  boundFmt [12];
        rst = 1'b1;
        in_valid = 1'b1;
        out_ready = 1'b1;
        applyStimulus(2'd0, 1'b0, 5'd5, 5'd6, 5'd0, 3'd0, 32'hFFFFFFFF);
        modelReset();

        // Reset holds everything idle even with a request pending.
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("rst_out_inst", out_inst, 32'd0);
        checkOutput("rst_inst_count", {16'd0, inst_count}, 32'd0);
        checkOutput("rst_err_count", {24'd0, err_count}, 32'd0);
        rst = 1'b0;

        directedReq("I_opimm", 2'd0, 1'b0, 5'd5, 5'd6, 5'd0, 3'd0, 32'hFFFFFFFF, 32'hFFF30293, 1'b0);
        directedReq("I_load", 2'd0, 1'b1, 5'd5, 5'd6, 5'd0, 3'd0, 32'hFFFFFFFF, 32'hFFF30283, 1'b0);

        // Reset in the middle of traffic discards a pending entry.
        out_ready = 1'b0;
        sendReq(2'd1, 1'b0, 5'd0, 5'd1, 5'd2, 3'd0, 32'd4);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        checkOutput("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("midrst_inst_count", {16'd0, inst_count}, 32'd0);
        modelReset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;

        directedReq("S_enc", 2'd1, 1'b0, 5'd0, 5'd8, 5'd2, 3'd2, 32'd8, 32'h00242423, 1'b0);
        directedReq("B_enc", 2'd2, 1'b0, 5'd0, 5'd1, 5'd2, 3'd1, 32'hFFFFFFFC, 32'hFE209EE3, 1'b0);
        directedReq("J_enc", 2'd3, 1'b0, 5'd1, 5'd0, 5'd0, 3'd0, 32'd2048, 32'h001000EF, 1'b0);
        checkOutput("count_after_3", {16'd0, inst_count}, 32'd3);

        directedReq("I_range_err", 2'd0, 1'b0, 5'd1, 5'd1, 5'd0, 3'd0, 32'd2048, 32'h00000013, 1'b1);
        checkOutput("err_count_1", {24'd0, err_count}, 32'd1);
        directedReq("B_even", 2'd2, 1'b0, 5'd0, 5'd0, 5'd0, 3'd0, 32'd6, 32'h00000363, 1'b0);
        directedReq("B_odd", 2'd2, 1'b0, 5'd0, 5'd0, 5'd0, 3'd0, 32'd5, 32'h00000013, 1'b1);
        checkOutput("err_count_2", {24'd0, err_count}, 32'd2);

        // Range boundaries on both sides for every format.
        bounds   = '{32'd2047, 32'hFFFFF800, 32'hFFFFF7FF, 32'd2048,
                     32'd4094, 32'hFFFFF000, 32'd4096, 32'hFFFFEFFE,
                     32'h000FFFFE, 32'hFFF00000, 32'h00100000, 32'h000FFFFF};
        boundFmt = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2,
                     2'd3, 2'd3, 2'd3, 2'd3};
        for (int b = 0; b < 12; b++) begin
            sendReq(boundFmt[b], 1'b0, 5'd3, 5'd4, 5'd7, 3'd5, bounds[b]);
        end
        in_valid = 1'b0;
        stepCycle();

        // Backpressure: two fill the FIFO, the third waits for a pop.
        out_ready = 1'b0;
        applyStimulus(2'd1, 1'b0, 5'd0, 5'd1, 5'd2, 3'd2, 32'd100);
        in_valid = 1'b1;
        stepCycle();
        applyStimulus(2'd1, 1'b0, 5'd0, 5'd1, 5'd2, 3'd2, 32'd200);
        stepCycle();
        applyStimulus(2'd1, 1'b0, 5'd0, 5'd1, 5'd2, 3'd2, 32'd300);
        checkOutput("bp_full_ready", {31'd0, in_ready}, 32'd0);
        stepCycle();
        out_ready = 1'b1;
        checkOutput("bp_ready_with_pop", {31'd0, in_ready}, 32'd0);
        stepCycle();
        checkOutput("bp_reassert", {31'd0, in_ready}, 32'd1);
        stepCycle();
        in_valid = 1'b0;
        repeat (2) stepCycle();

        // Continuous push+pop holds occupancy at one.
        in_valid = 1'b1;
        for (int s = 0; s < 6; s++) begin
            applyStimulus(2'd0, 1'b0, 5'(s), 5'(s + 1), 5'd0, 3'd0, 32'(s * 7));
            stepCycle();
            checkOutput("pushpop_ready", {31'd0, in_ready}, 32'd1);
        end
        in_valid = 1'b0;
        stepCycle();

        for (int n = 0; n < 300; n++) begin
            sendReq(2'd0, 1'b0, 5'd1, 5'd1, 5'd0, 3'd0, 32'h00010000);
        end
        in_valid = 1'b0;
        stepCycle();
        checkOutput("err_saturated", {24'd0, err_count}, 32'd255);

        for (int n = 0; n < 1000; n++) begin
            randomReq(1'b1);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            stepCycle();
        end
        for (int n = 0; n < 200; n++) begin
            randomReq(1'b0);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            stepCycle();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) stepCycle();

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
